multicycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences the shared ALU, register file, memory port and PC over fetch/decode/execute/memory/writeback steps.
- Drives the 3-bit ALUOp consumed by ALUctrl. Encodings: 000 add (lw/sw/addi), 001 subi, 010 R-type funct-decoded, 101 branch compare (sub).
- Sits between the instruction register (opcode) and all datapath mux selects and write enables.

---
 rtl/multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style main control FSM for the multi-cycle MIPS datapath. Sequences
//   the shared ALU, register file, memory port and PC through
//   fetch / decode / execute / memory / writeback steps.
//
// Optional feature (macro MC_PERF_CNT_EN):
//   Adds a 32-bit 'retired' counter output. It counts completed instructions,
//   i.e. every transition into FETCH out of a final instruction step.
//
// Ports:
//   clk            in   1  clock, rising edge
//   rst            in   1  synchronous active-high reset
//   opcode         in   6  instruction[31:26] from the instruction register
//   mem_ready      in   1  memory completes the current read/write this cycle
//   pc_write       out  1  unconditional PC load
//   pc_write_cond  out  1  PC load if ALU zero
//   i_or_d         out  1  memory address select: 0 = PC, 1 = ALUOut
//   mem_read       out  1  memory read request
//   mem_write      out  1  memory write request
//   ir_write       out  1  instruction register load
//   mem_to_reg     out  1  writeback data select: 1 = MDR
//   reg_dst        out  1  destination register: 1 = rd, 0 = rt
//   reg_write      out  1  register file write
//   alu_src_a      out  1  ALU A select: 0 = PC, 1 = A
//   alu_src_b      out  2  ALU B select: 00 B, 01 4, 10 sext imm, 11 imm<<2
//   alu_op         out  3  to ALUctrl: 000 add, 001 sub, 010 funct, 101 beq
//   pc_source      out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target
//   illegal        out  1  sticky unsupported-opcode flag
//   state          out  4  current FSM state (debug)
//   retired        out 32  retired instruction count (MC_PERF_CNT_EN only)
//
// Memory handshake: mem_read / mem_write are held as a request for as long as
// the FSM sits in FETCH, MEMRD or MEMWR; the cycle in which mem_ready is high
// completes the access and the FSM advances on that clock edge. mem_ready is
// ignored in every other state.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_ADDI  = 6'd8,
  parameter logic [5:0] OP_SUBI  = 6'd9,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic [3:0]  state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_set_illegal;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_RTYPE:         w_next = S_REXEC;
          OP_ADDI, OP_SUBI: w_next = S_IEXEC;
          OP_BEQ:           w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      // Only LW and SW reach MEMADR, so anything but SW is treated as a load.
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_REXEC:  w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_IEXEC:  w_next = S_IWB;
      S_IWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (state plus mem_ready only)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed, together
        // with the IR load, in the cycle the read completes.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) into ALUOut.
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_SUBI) ? 3'b001 : 3'b000;
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b101;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: begin
      end
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;

`ifdef MC_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Retired-instruction counter. HALT never transitions to FETCH, so the
  // count naturally holds there.
  // ---------------------------------------------------------------------------
  logic [31:0] r_retired;
  logic        w_retire;

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP:
        w_retire = (w_next == S_FETCH);
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= 32'd0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Bench for multicycle_ctrl. A table of per-cycle {rst, opcode, mem_ready,
//   expected outputs} records is applied in a loop; each record's expected
//   output vector goes into a queue when its inputs are driven and is popped
//   and compared once the outputs settle. Hand-written sequences cover reset
//   holds, reset during a memory wait and (with MC_PERF_CNT_EN) the retired
//   counter.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int W = 22;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .state         (state)
`ifdef MC_PERF_CNT_EN
    ,
    .retired       (retired)
`endif
  );

  // {state, illegal, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  //  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
  //  pc_source}
  logic [W-1:0] obs;
  assign obs = {state, illegal, pc_write, pc_write_cond, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_source};

  // ---------------------------------------------------------------------------
  // Expected output vectors per state, written straight from the state table.
  // Flag order: pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa.
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] mkv(input logic [3:0] st, input logic ill,
                                       input logic [9:0] f, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic [1:0] psrc);
    return {st, ill, f, asb, aop, psrc};
  endfunction

  logic [W-1:0] o_idle, o_fetch_rdy, o_fetch_wait, o_decode, o_memadr, o_memrd;
  logic [W-1:0] o_memwb, o_memwr, o_rexec, o_rwb, o_iexec_add, o_iexec_sub;
  logic [W-1:0] o_iwb, o_branch, o_jump, o_halt;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs, then compare the settled outputs.
  task automatic apply(input logic r, input logic [5:0] op, input logic mr,
                       input logic [W-1:0] e, input string nm);
    logic [W-1:0] want;
    @(negedge clk);
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(e);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
               nm, obs, want, obs[W-1 -: 4], want[W-1 -: 4]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         r;
    logic [5:0]   op;
    logic         mr;
    logic [W-1:0] e;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic r, input logic [5:0] op, input logic mr, input logic [W-1:0] e);
    vec_t v;
    v.r = r; v.op = op; v.mr = mr; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) add_v(1'b0, op, 1'b0, o_fetch_wait);
    add_v(1'b0, op, 1'b1, o_fetch_rdy);
  endtask

  task automatic add_lw(input int waits);
    add_fetch(6'd35, 0);
    add_v(1'b0, 6'd35, 1'b1, o_decode);
    add_v(1'b0, 6'd35, 1'b1, o_memadr);
    for (int i = 0; i < waits; i++) add_v(1'b0, 6'd35, 1'b0, o_memrd);
    add_v(1'b0, 6'd35, 1'b1, o_memrd);
    add_v(1'b0, 6'd35, 1'b1, o_memwb);
  endtask

  task automatic add_sw(input int waits);
    add_fetch(6'd43, 0);
    add_v(1'b0, 6'd43, 1'b1, o_decode);
    add_v(1'b0, 6'd43, 1'b1, o_memadr);
    for (int i = 0; i < waits; i++) add_v(1'b0, 6'd43, 1'b0, o_memwr);
    add_v(1'b0, 6'd43, 1'b1, o_memwr);
  endtask

  task automatic add_r();
    add_fetch(6'd0, 0);
    add_v(1'b0, 6'd0, 1'b1, o_decode);
    add_v(1'b0, 6'd0, 1'b1, o_rexec);
    add_v(1'b0, 6'd0, 1'b1, o_rwb);
  endtask

  // mem_ready is low in the non-waiting steps to show it is ignored there.
  task automatic add_imm(input logic [5:0] op, input logic [W-1:0] ex);
    add_fetch(op, 0);
    add_v(1'b0, op, 1'b0, o_decode);
    add_v(1'b0, op, 1'b0, ex);
    add_v(1'b0, op, 1'b0, o_iwb);
  endtask

  task automatic add_beq(input int fetch_waits);
    add_fetch(6'd4, fetch_waits);
    add_v(1'b0, 6'd4, 1'b1, o_decode);
    add_v(1'b0, 6'd4, 1'b1, o_branch);
  endtask

  task automatic add_j();
    add_fetch(6'd2, 0);
    add_v(1'b0, 6'd2, 1'b1, o_decode);
    add_v(1'b0, 6'd2, 1'b1, o_jump);
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].op, vecs[i].mr, vecs[i].e, $sformatf("%s_vec%0d", tag, i));
    end
    vecs.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    o_idle       = mkv(4'd0,  1'b0, 10'b0000000000, 2'b00, 3'b000, 2'b00);
    o_fetch_rdy  = mkv(4'd1,  1'b0, 10'b1001010000, 2'b01, 3'b000, 2'b00);
    o_fetch_wait = mkv(4'd1,  1'b0, 10'b0001000000, 2'b01, 3'b000, 2'b00);
    o_decode     = mkv(4'd2,  1'b0, 10'b0000000000, 2'b11, 3'b000, 2'b00);
    o_memadr     = mkv(4'd3,  1'b0, 10'b0000000001, 2'b10, 3'b000, 2'b00);
    o_memrd      = mkv(4'd4,  1'b0, 10'b0011000000, 2'b00, 3'b000, 2'b00);
    o_memwb      = mkv(4'd5,  1'b0, 10'b0000001010, 2'b00, 3'b000, 2'b00);
    o_memwr      = mkv(4'd6,  1'b0, 10'b0010100000, 2'b00, 3'b000, 2'b00);
    o_rexec      = mkv(4'd7,  1'b0, 10'b0000000001, 2'b00, 3'b010, 2'b00);
    o_rwb        = mkv(4'd8,  1'b0, 10'b0000000110, 2'b00, 3'b000, 2'b00);
    o_iexec_add  = mkv(4'd9,  1'b0, 10'b0000000001, 2'b10, 3'b000, 2'b00);
    o_iexec_sub  = mkv(4'd9,  1'b0, 10'b0000000001, 2'b10, 3'b001, 2'b00);
    o_iwb        = mkv(4'd10, 1'b0, 10'b0000000010, 2'b00, 3'b000, 2'b00);
    o_branch     = mkv(4'd11, 1'b0, 10'b0100000001, 2'b00, 3'b101, 2'b01);
    o_jump       = mkv(4'd12, 1'b0, 10'b1000000000, 2'b00, 3'b000, 2'b10);
    o_halt       = mkv(4'd13, 1'b1, 10'b0000000000, 2'b00, 3'b000, 2'b00);

    // Initial reset edge brings the FSM out of its unknown power-up state.
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);

    // Main table: reset release then a mix of instructions and wait states.
    add_v(1'b1, 6'd0, 1'b1, o_idle);   // second reset cycle
    add_v(1'b0, 6'd0, 1'b1, o_idle);   // release cycle, still IDLE
    add_lw(0);                         // 1,2,3,4,5
    add_r();                           // 1,2,7,8
    add_imm(6'd9, o_iexec_sub);
    add_imm(6'd8, o_iexec_add);
    add_sw(3);                         // mem_write held 4 cycles
    add_beq(1);                        // one FETCH wait cycle
    add_j();
    add_lw(2);                         // MEMRD waits
    add_fetch(6'd63, 0);
    add_v(1'b0, 6'd63, 1'b1, o_decode);
    add_v(1'b0, 6'd63, 1'b1, o_halt);
    add_v(1'b0, 6'd63, 1'b0, o_halt);
    add_v(1'b0, 6'd0,  1'b1, o_halt);  // HALT ignores a legal opcode too
    add_v(1'b1, 6'd0,  1'b1, o_halt);  // reset sampled at end of this cycle
    add_v(1'b0, 6'd0,  1'b1, o_idle);  // illegal cleared
    add_v(1'b0, 6'd0,  1'b0, o_fetch_wait);
    run_table("main");

    // Reset held for a random number of cycles with random inputs: IDLE only.
    begin
      int n;
      logic mr;
      logic [5:0] op;
      n  = $urandom_range(2, 5);
      mr = 1'($urandom_range(0, 1));
      op = 6'($urandom_range(0, 63));
      apply(1'b1, op, mr, mr ? o_fetch_rdy : o_fetch_wait, "rst_enter");
      for (int i = 0; i < n; i++) begin
        mr = 1'($urandom_range(0, 1));
        op = 6'($urandom_range(0, 63));
        apply(1'b1, op, mr, o_idle, $sformatf("rst_hold%0d", i));
      end
      apply(1'b0, 6'd0, 1'b1, o_idle, "rst_release");
    end
`ifdef MC_PERF_CNT_EN
    check_val("retired_after_reset", retired, 32'd0);
`endif

    // lw, R-type, beq, j back to back: four retirements.
    add_lw(0);
    add_r();
    add_beq(0);
    add_j();
    run_table("perf");

    // Reset in the middle of a MEMRD wait drops the pending read.
    apply(1'b0, 6'd35, 1'b1, o_fetch_rdy, "mid_fetch");
`ifdef MC_PERF_CNT_EN
    check_val("retired_four", retired, 32'd4);
`endif
    apply(1'b0, 6'd35, 1'b1, o_decode, "mid_decode");
    apply(1'b0, 6'd35, 1'b1, o_memadr, "mid_memadr");
    apply(1'b0, 6'd35, 1'b0, o_memrd, "mid_memrd_wait");
    apply(1'b1, 6'd35, 1'b0, o_memrd, "mid_memrd_rst");
    apply(1'b0, 6'd35, 1'b1, o_idle, "mid_after_rst");
`ifdef MC_PERF_CNT_EN
    check_val("retired_cleared", retired, 32'd0);
`endif
    apply(1'b0, 6'd35, 1'b1, o_fetch_rdy, "mid_refetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
